// File: rtl/cm_pkg.sv
// Shared definitions for the counter-machine core: opcodes, ALU codes, decode bundle.
package cm_pkg;

    localparam int unsigned OP_W       = 3;
    localparam int unsigned ALU_W      = 3;
    // Bundle fields are sized for the widest supported configuration;
    // each stage slices the low bits it was built for.
    localparam int unsigned RA_MAX_W   = 8;
    localparam int unsigned DATA_MAX_W = 32;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b001;
    localparam logic [OP_W-1:0] OP_INC  = 3'b010;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b011;
    localparam logic [OP_W-1:0] OP_CPY  = 3'b100;
    localparam logic [OP_W-1:0] OP_JMPZ = 3'b101;
    localparam logic [OP_W-1:0] OP_JMPE = 3'b110;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    localparam logic [ALU_W-1:0] ALU_CLR = 3'b000;
    localparam logic [ALU_W-1:0] ALU_INC = 3'b001;
    localparam logic [ALU_W-1:0] ALU_DEC = 3'b010;
    localparam logic [ALU_W-1:0] ALU_JZ  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_CPY = 3'b100;
    localparam logic [ALU_W-1:0] ALU_JE  = 3'b101;

    typedef struct packed {
        logic [RA_MAX_W-1:0]   a_addr;
        logic [RA_MAX_W-1:0]   b_addr;
        logic [DATA_MAX_W-1:0] imm;
        logic [ALU_W-1:0]      alu_op;
        logic                  wb;
        logic                  jmp;
        logic                  halt;
        logic                  illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction decoder: instr fields -> dec_bundle_t.
module decode_comb
    import cm_pkg::*;
#(
    parameter  int unsigned RA_W    = 1,
    parameter  int unsigned IMM_F_W = 3,
    parameter  int unsigned DATA_W  = 8,
    localparam int unsigned INSTR_W = 3 + 2*RA_W + IMM_F_W
) (
    input  logic [INSTR_W-1:0] instr,
    output dec_bundle_t        bundle_c
);

    localparam int unsigned JZ_W = RA_W + IMM_F_W;

    logic [OP_W-1:0]    op;
    logic [RA_W-1:0]    ra;
    logic [RA_W-1:0]    rb;
    logic [IMM_F_W-1:0] f;
    logic [JZ_W-1:0]    jz_off;
    logic [DATA_W-1:0]  imm_jz;
    logic [DATA_W-1:0]  imm_je;

    assign op     = instr[INSTR_W-1 -: 3];
    assign ra     = instr[INSTR_W-4 -: RA_W];
    assign rb     = instr[INSTR_W-4-RA_W -: RA_W];
    assign f      = instr[IMM_F_W-1:0];
    assign jz_off = {rb, f};
    assign imm_jz = DATA_W'($signed(jz_off));
    assign imm_je = DATA_W'($signed(f));

    // Opcode decode; fields an opcode does not use stay at zero.
    always_comb begin
        bundle_c = '0;
        case (op)
            OP_NOP: begin
                bundle_c.illegal = (|ra) || (|rb) || (|f);
            end
            OP_CLR, OP_INC, OP_DEC: begin
                bundle_c.a_addr  = RA_MAX_W'(ra);
                bundle_c.wb      = 1'b1;
                bundle_c.alu_op  = (op == OP_CLR) ? ALU_CLR :
                                   (op == OP_INC) ? ALU_INC : ALU_DEC;
                bundle_c.illegal = (|rb) || (|f);
            end
            OP_CPY: begin
                bundle_c.a_addr  = RA_MAX_W'(ra);
                bundle_c.b_addr  = RA_MAX_W'(rb);
                bundle_c.wb      = 1'b1;
                bundle_c.alu_op  = ALU_CPY;
                bundle_c.illegal = |f;
            end
            OP_JMPZ: begin
                bundle_c.a_addr = RA_MAX_W'(ra);
                bundle_c.jmp    = 1'b1;
                bundle_c.alu_op = ALU_JZ;
                bundle_c.imm    = DATA_MAX_W'(imm_jz);
            end
            OP_JMPE: begin
                bundle_c.a_addr = RA_MAX_W'(ra);
                bundle_c.b_addr = RA_MAX_W'(rb);
                bundle_c.jmp    = 1'b1;
                bundle_c.alu_op = ALU_JE;
                bundle_c.imm    = DATA_MAX_W'(imm_je);
            end
            OP_HALT: begin
                bundle_c.halt    = 1'b1;
                bundle_c.illegal = (|ra) || (|rb) || (|f);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register + one-entry skid, sticky halt, flush, issue counter.
module decode_stage
    import cm_pkg::*;
#(
    parameter  int unsigned RA_W    = 1,
    parameter  int unsigned IMM_F_W = 3,
    parameter  int unsigned DATA_W  = 8,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned INSTR_W = 3 + 2*RA_W + IMM_F_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RA_W-1:0]    a_addr,
    output logic [RA_W-1:0]    b_addr,
    output logic [DATA_W-1:0]  imm,
    output logic [ALU_W-1:0]   alu_op,
    output logic               wb,
    output logic               jmp,
    output logic               halt,
    output logic               illegal,
    output logic [CNT_W-1:0]   issued
);

    dec_bundle_t      dec_c;
    dec_bundle_t      out_q, out_d;
    dec_bundle_t      skid_q, skid_d;
    logic             out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             halted_q, halted_d;
    logic             in_ready_d;
    logic [CNT_W-1:0] issued_d;
    logic             accept_c;
    logic             consume_c;
    logic             unused_hi;

    decode_comb #(
        .RA_W    (RA_W),
        .IMM_F_W (IMM_F_W),
        .DATA_W  (DATA_W)
    ) u_decode_comb (
        .instr    (instr),
        .bundle_c (dec_c)
    );

    assign accept_c  = in_valid && in_ready;
    assign consume_c = out_valid && out_ready;

    // Next-state for output slot, skid slot, halt flag, ready and issue count.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        halted_d     = halted_q;
        issued_d     = issued;

        if (consume_c) begin
            issued_d = issued + CNT_W'(1);
        end

        if (flush) begin
            // Flush beats a same-cycle accept: that instruction is dropped.
            out_d        = '0;
            out_valid_d  = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
            halted_d     = 1'b0;
        end else begin
            if (consume_c || !out_valid) begin
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept_c) begin
                    out_d       = dec_c;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept_c) begin
                skid_d       = dec_c;
                skid_valid_d = 1'b1;
            end
            if (accept_c && dec_c.halt) begin
                halted_d = 1'b1;
            end
        end

        in_ready_d = !skid_valid_d && !halted_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid    <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            in_ready     <= 1'b0;
            issued       <= '0;
        end else begin
            out_q        <= out_d;
            out_valid    <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            halted_q     <= halted_d;
            in_ready     <= in_ready_d;
            issued       <= issued_d;
        end
    end

    assign a_addr  = out_q.a_addr[RA_W-1:0];
    assign b_addr  = out_q.b_addr[RA_W-1:0];
    assign imm     = out_q.imm[DATA_W-1:0];
    assign alu_op  = out_q.alu_op;
    assign wb      = out_q.wb;
    assign jmp     = out_q.jmp;
    assign halt    = out_q.halt;
    assign illegal = out_q.illegal;

    // Bundle bits above the configured widths are carried but never read.
    assign unused_hi = ^{out_q.a_addr, out_q.b_addr, out_q.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage at default parameters.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  instr;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  a_addr;
    logic [0:0]  b_addr;
    logic [7:0]  imm;
    logic [2:0]  alu_op;
    logic        wb;
    logic        jmp;
    logic        halt;
    logic        illegal;
    logic [15:0] issued;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    decode_stage #(
        .RA_W    (1),
        .IMM_F_W (3),
        .DATA_W  (8),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .imm       (imm),
        .alu_op    (alu_op),
        .wb        (wb),
        .jmp       (jmp),
        .halt      (halt),
        .illegal   (illegal),
        .issued    (issued)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 8'h00;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_issued",    32'(issued),    32'd0);
        chk("rst_bundle",    {19'd0, a_addr, b_addr, imm, alu_op, wb, jmp, halt, illegal}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Stream CLR r0, INC r1, DEC r0
        in_valid = 1'b1;
        instr    = 8'h20;
        chk("pre_accept_out_valid", 32'(out_valid), 32'd0);
        step();
        chk("clr_valid", 32'(out_valid), 32'd1);
        chk("clr_alu",   32'(alu_op), 32'd0);
        chk("clr_a",     32'(a_addr), 32'd0);
        chk("clr_wb",    32'(wb), 32'd1);
        instr = 8'h50;
        step();
        chk("inc_alu", 32'(alu_op), 32'd1);
        chk("inc_a",   32'(a_addr), 32'd1);
        chk("inc_wb",  32'(wb), 32'd1);
        instr = 8'h60;
        step();
        chk("dec_alu", 32'(alu_op), 32'd2);
        chk("dec_a",   32'(a_addr), 32'd0);
        chk("dec_wb",  32'(wb), 32'd1);
        in_valid = 1'b0;
        step();
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_issued",  32'(issued), 32'd3);

        // Sign extension and jump decode
        in_valid = 1'b1;
        instr    = 8'hBF;
        step();
        chk("jmpz_imm", 32'(imm), 32'hFF);
        chk("jmpz_alu", 32'(alu_op), 32'd3);
        chk("jmpz_jmp", 32'(jmp), 32'd1);
        chk("jmpz_a",   32'(a_addr), 32'd1);
        chk("jmpz_b",   32'(b_addr), 32'd0);
        chk("jmpz_wb",  32'(wb), 32'd0);
        instr = 8'hCB;
        step();
        chk("jmpe_imm", 32'(imm), 32'h03);
        chk("jmpe_b",   32'(b_addr), 32'd1);
        chk("jmpe_a",   32'(a_addr), 32'd0);
        chk("jmpe_alu", 32'(alu_op), 32'd5);
        chk("jmpe_jmp", 32'(jmp), 32'd1);

        // Illegal field detection
        instr = 8'h01;
        step();
        chk("nop_f_illegal", 32'(illegal), 32'd1);
        chk("nop_f_ctrl",    {29'd0, wb, jmp, halt}, 32'd0);
        chk("nop_f_imm",     32'(imm), 32'd0);
        instr = 8'h90;
        step();
        chk("cpy_illegal", 32'(illegal), 32'd0);
        chk("cpy_alu",     32'(alu_op), 32'd4);
        chk("cpy_a",       32'(a_addr), 32'd1);
        chk("cpy_b",       32'(b_addr), 32'd0);
        in_valid = 1'b0;
        step();
        chk("decode_issued", 32'(issued), 32'd7);

        // Backpressure: two accepted into out + skid, third held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 8'h40;
        step();
        chk("bp1_valid",    32'(out_valid), 32'd1);
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        instr = 8'h50;
        step();
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        chk("bp2_hold_a",   32'(a_addr), 32'd0);
        instr = 8'h60;
        step();
        chk("bp3_in_ready", 32'(in_ready), 32'd0);
        chk("bp3_hold_a",   32'(a_addr), 32'd0);
        chk("bp3_hold_alu", 32'(alu_op), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_skid_out_valid", 32'(out_valid), 32'd1);
        chk("bp_skid_out_a",     32'(a_addr), 32'd1);
        chk("bp_ready_back",     32'(in_ready), 32'd1);
        step();
        chk("bp_no_dup", 32'(out_valid), 32'd0);
        chk("bp_issued", 32'(issued), 32'd9);

        // Sticky halt, then flush
        in_valid = 1'b1;
        instr    = 8'hE0;
        step();
        chk("halt_bundle",   32'(halt), 32'd1);
        chk("halt_valid",    32'(out_valid), 32'd1);
        chk("halt_in_ready", 32'(in_ready), 32'd0);
        instr = 8'h50;
        step();
        chk("halt_blocks_inc", 32'(out_valid), 32'd0);
        chk("halt_sticky",     32'(in_ready), 32'd0);
        step();
        chk("halt_sticky2", 32'(in_ready), 32'd0);
        chk("halt_issued",  32'(issued), 32'd10);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready", 32'(in_ready), 32'd1);

        // Flush beats a simultaneous accept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 8'h20;
        step();
        chk("fa_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        instr = 8'h50;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fa_valid_cleared", 32'(out_valid), 32'd0);
        chk("fa_in_ready",      32'(in_ready), 32'd1);
        step();
        chk("fa_dropped", 32'(out_valid), 32'd0);
        chk("fa_issued",  32'(issued), 32'd10);

        // Reset mid-stream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 8'h50;
        step();
        chk("mr_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_issued",    32'(issued), 32'd0);
        chk("mr_bundle",    {19'd0, a_addr, b_addr, imm, alu_op, wb, jmp, halt, illegal}, 32'd0);
        chk("mr_in_ready",  32'(in_ready), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        chk("mr_ready_after", 32'(in_ready), 32'd1);
        chk("mr_no_partial",  32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
